mux2_rr_arbiter: RTL and testbench

//   Two-channel round-robin arbiter and registered 2:1 mux stage with valid/ready handshakes.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux2_w.sv | 13 +
 rtl/mux2_rr_arbiter.sv | 91 +++++++++
 tb/tb_mux2_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the two-channel round-robin mux stage:
// FSM states, channel identifiers and the default payload width.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic CH0   = 1'b0;
  localparam logic CH1   = 1'b1;
  localparam int   W_DEF = 8;

endpackage

// File: rtl/mux2_w.sv
// W-bit combinational 2:1 mux; sel=0 passes i0, sel=1 passes i1.
module mux2_w #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  output logic [W-1:0] e
);

  assign e = sel ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-level round-robin arbiter over two valid/ready channels feeding a
// one-entry output register; a granted packet keeps the grant until its last beat.
module mux2_rr_arbiter
  import mux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i0_valid,
  input  logic [W-1:0] i0_data,
  input  logic         i0_last,
  output logic         i0_ready,
  input  logic         i1_valid,
  input  logic [W-1:0] i1_data,
  input  logic         i1_last,
  output logic         i1_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_sel,
  input  logic         o_ready
);

  state_t       state;
  logic         ptr;
  logic         grant;
  logic         load_en;
  logic         xfer;
  logic [W+1:0] sel_beat;
  logic         sel_valid;
  logic         sel_last;
  logic [W-1:0] sel_data;

  // ptr names the channel that won the previous packet; ~ptr is preferred next.
  always_comb begin
    // NOTE: grant gets a default before the case so no path leaves it unassigned (no latch).
    grant = ~ptr;
    unique case (state)
      ST_IDLE:  if (i0_valid ^ i1_valid) grant = i1_valid ? CH1 : CH0;
      ST_LOCK0: grant = CH0;
      ST_LOCK1: grant = CH1;
      default:  grant = ~ptr;
    endcase
  end

  mux2_w #(.W(W + 2)) u_mux (
    .sel (grant),
    .i0  ({i0_valid, i0_last, i0_data}),
    .i1  ({i1_valid, i1_last, i1_data}),
    .e   (sel_beat)
  );

  assign {sel_valid, sel_last, sel_data} = sel_beat;

  assign load_en  = ~o_valid | o_ready;
  assign xfer     = sel_valid & load_en;
  assign i0_ready = rst_n & load_en & (grant == CH0);
  assign i1_ready = rst_n & load_en & (grant == CH1);

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_sel   <= CH0;
      state   <= ST_IDLE;
      ptr     <= 1'b1;
    end else begin
      if (load_en) begin
        o_valid <= xfer;
        if (xfer) begin
          o_data <= sel_data;
          o_last <= sel_last;
          o_sel  <= grant;
        end
      end
      // Fairness is per packet: ptr only moves when a last beat is taken.
      if (xfer) begin
        if (sel_last) begin
          state <= ST_IDLE;
          ptr   <= grant;
        end else if (state == ST_IDLE) begin
          state <= (grant == CH1) ? ST_LOCK1 : ST_LOCK0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: queue-fed sources, a scoreboard of
// expected {sel,last,data} beats and a monitor that checks every consumed beat.
module tb_mux2_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i0_valid, i0_last, i0_ready;
  logic [W-1:0] i0_data;
  logic         i1_valid, i1_last, i1_ready;
  logic [W-1:0] i1_data;
  logic         o_valid, o_last, o_sel, o_ready;
  logic [W-1:0] o_data;

  logic [W:0]   q0[$];
  logic [W:0]   q1[$];
  logic [W+1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_last  (i1_last),
    .i1_ready (i1_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_sel    (o_sel),
    .o_ready  (o_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  // Source 0: presents the queue head, holds it until accepted.
  initial begin
    logic         pend;
    logic [W:0]   held;
    pend = 1'b0;
    held = '0;
    i0_valid = 1'b0; i0_data = '0; i0_last = 1'b0;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        i0_valid = 1'b1;
        {i0_last, i0_data} = q0[0];
      end else begin
        i0_valid = 1'b0;
      end
      if (rst_n && pend)
        assert (i0_valid && {i0_last, i0_data} == held)
          else $error("channel 0 dropped or changed a pending beat");
      #4;
      pend = rst_n && i0_valid && !i0_ready;
      held = {i0_last, i0_data};
      if (i0_valid && i0_ready) void'(q0.pop_front());
    end
  end

  initial begin
    logic         pend;
    logic [W:0]   held;
    pend = 1'b0;
    held = '0;
    i1_valid = 1'b0; i1_data = '0; i1_last = 1'b0;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        i1_valid = 1'b1;
        {i1_last, i1_data} = q1[0];
      end else begin
        i1_valid = 1'b0;
      end
      if (rst_n && pend)
        assert (i1_valid && {i1_last, i1_data} == held)
          else $error("channel 1 dropped or changed a pending beat");
      #4;
      pend = rst_n && i1_valid && !i1_ready;
      held = {i1_last, i1_data};
      if (i1_valid && i1_ready) void'(q1.pop_front());
    end
  end

  // Monitor: every beat the consumer takes must match the scoreboard head.
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got sel=%0d last=%0d data='h%0h, expected no beat at %0t",
                   o_sel, o_last, o_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", {22'd0, o_sel, o_last, o_data}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Encodes an expected output beat as {sel,last,data}.
  function automatic logic [W+1:0] beat(input logic sel, input logic last, input logic [W-1:0] d);
    return {sel, last, d};
  endfunction

  initial begin
    rst_n   = 1'b0;
    o_ready = 1'b0;

    // 1: reset with both channels valid
    q0.push_back({1'b1, 8'h01});
    q1.push_back({1'b1, 8'h02});
    repeat (3) begin
      @(negedge clk);
      #4;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_i0_ready", i0_ready, 0);
      check("rst_i1_ready", i1_ready, 0);
    end
    @(negedge clk);
    exp_q.push_back(beat(1'b0, 1'b1, 8'h01));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h02));
    o_ready = 1'b1;
    rst_n   = 1'b1;
    drain();

    // 2: single beat on channel 0, one-cycle latency
    #1;
    q0.push_back({1'b1, 8'hA5});
    exp_q.push_back(beat(1'b0, 1'b1, 8'hA5));
    @(negedge clk);
    #4;
    check("single_i0_ready", i0_ready, 1);
    @(negedge clk);
    #1;
    check("single_o_valid", o_valid, 1);
    check("single_o_data", o_data, 8'hA5);
    check("single_o_sel", o_sel, 0);
    drain();

    // Re-reset so channel 0 wins the next contention
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 3: continuous contention with single-beat packets
    #1;
    q0.push_back({1'b1, 8'h30}); q0.push_back({1'b1, 8'h31});
    q1.push_back({1'b1, 8'h40}); q1.push_back({1'b1, 8'h41});
    exp_q.push_back(beat(1'b0, 1'b1, 8'h30));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h40));
    exp_q.push_back(beat(1'b0, 1'b1, 8'h31));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h41));
    drain();

    // 4: channel 0 packet holds the grant while channel 1 waits
    #1;
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    q1.push_back({1'b1, 8'h44});
    exp_q.push_back(beat(1'b0, 1'b0, 8'h11));
    exp_q.push_back(beat(1'b0, 1'b0, 8'h22));
    exp_q.push_back(beat(1'b0, 1'b1, 8'h33));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h44));
    @(negedge clk);
    @(negedge clk);
    #4;
    check("lock_i1_ready", i1_ready, 0);
    drain();

    // 5: backpressure for 4 cycles while the output register is full
    o_ready = 1'b0;
    #1;
    q0.push_back({1'b1, 8'h50}); q0.push_back({1'b1, 8'h51});
    q1.push_back({1'b1, 8'h60});
    exp_q.push_back(beat(1'b0, 1'b1, 8'h50));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h60));
    exp_q.push_back(beat(1'b0, 1'b1, 8'h51));
    @(negedge clk);
    @(negedge clk);
    repeat (4) begin
      #4;
      check("bp_o_valid", o_valid, 1);
      check("bp_o_data", o_data, 8'h50);
      check("bp_i0_ready", i0_ready, 0);
      check("bp_i1_ready", i1_ready, 0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    drain();

    // 6: reset after the second beat of a channel 1 packet
    #1;
    q1.push_back({1'b0, 8'h70}); q1.push_back({1'b0, 8'h71}); q1.push_back({1'b1, 8'h72});
    exp_q.push_back(beat(1'b1, 1'b0, 8'h70));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q1.delete();
    @(negedge clk);
    #4;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_i1_ready", i1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    q0.push_back({1'b1, 8'h80});
    q1.push_back({1'b1, 8'h90});
    exp_q.push_back(beat(1'b0, 1'b1, 8'h80));
    exp_q.push_back(beat(1'b1, 1'b1, 8'h90));
    drain();

    check("final_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
